s2p_deframer: RTL and testbench

Serial-in, parallel-out deframer that sits directly downstream of the team's parallel-to-serial shift register. It collects an LSB-first serial bit stream into DATA_WIDTH-bit words and presents each completed word on a single-entry valid/ready output register. Partial frames are abandoned on restart. Completed words that cannot be accepted are dropped and flagged.

---
 rtl/s2p_deframer.sv | 119 +++++++++++
 tb/tb_s2p_deframer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/s2p_deframer.sv
// s2p_deframer: LSB-first serial-to-parallel deframer with a single-entry
// valid/ready output register. Optional even parity via `S2P_PARITY_EN.
//
// Ports:
//   clk, resetn     clock, synchronous active-low reset
//   sin, sin_start  serial bit, start-of-frame marker (bit 0)
//   dout            assembled word (DATA_WIDTH bits)
//   dout_valid      dout holds an unconsumed word
//   dout_ready      consumer accepts dout when dout_valid=1
//   dout_perr       parity error for dout (always 0 without the macro)
//   overrun         one-cycle pulse: a completed word was dropped
module s2p_deframer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  sin,
    input  logic                  sin_start,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_perr,
    output logic                  overrun
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

`ifdef S2P_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t                state;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] sreg;

    logic [DATA_WIDTH-1:0] shift_next;
    logic                  last_bit;
    logic                  done;
    logic [DATA_WIDTH-1:0] frame_word;
    logic                  frame_perr;

    // Bit indexed by the counter replaced with the incoming serial bit.
    always_comb begin
        shift_next = sreg;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (count == CW'(i))
                shift_next[i] = sin;
        end
        last_bit = (count == CW'(DATA_WIDTH - 1));
`ifdef S2P_PARITY_EN
        done       = (state == PARITY) && !sin_start;
        frame_word = sreg;
        frame_perr = ^{sreg, sin};
`else
        done       = (state == SHIFT) && !sin_start && last_bit;
        frame_word = shift_next;
        frame_perr = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            count      <= '0;
            sreg       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_perr  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;

            // A start marker always wins and silently drops any partial frame.
            if (sin_start) begin
                state <= SHIFT;
                count <= CW'(1);
                sreg  <= {{(DATA_WIDTH-1){1'b0}}, sin};
            end else begin
                case (state)
                    SHIFT: begin
                        sreg  <= shift_next;
                        count <= count + CW'(1);
                        if (last_bit) begin
`ifdef S2P_PARITY_EN
                            state <= PARITY;
`else
                            state <= IDLE;
                            count <= '0;
`endif
                        end
                    end
`ifdef S2P_PARITY_EN
                    PARITY: begin
                        state <= IDLE;
                        count <= '0;
                    end
`endif
                    default: ;
                endcase
            end

            // Drain and load in the same edge is lossless.
            if (done) begin
                if (!dout_valid || dout_ready) begin
                    dout       <= frame_word;
                    dout_perr  <= frame_perr;
                    dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_s2p_deframer.sv
// tb_s2p_deframer: scoreboard bench for s2p_deframer (DATA_WIDTH=16).
// Honours `S2P_PARITY_EN for frame length and parity expectations.
module tb_s2p_deframer;

    localparam int DW = 16;
`ifdef S2P_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk;
    logic          resetn;
    logic          sin;
    logic          sin_start;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_perr;
    logic          overrun;

    s2p_deframer #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .sin        (sin),
        .sin_start  (sin_start),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_perr  (dout_perr),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          p;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   ovr_seen = 0;
    int   ovr_exp = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_perr(input logic [DW-1:0] w, input logic pb);
        return PAR ? ((^w) ^ pb) : 1'b0;
    endfunction

    task automatic push(input logic [DW-1:0] w, input logic pb);
        exp_t e;
        e.d = w;
        e.p = exp_perr(w, pb);
        q.push_back(e);
    endtask

    // Drives one full frame starting in the current cycle; returns in the
    // first cycle after the final bit. rdy_last raises dout_ready for the
    // cycle whose ending edge completes the frame.
    task automatic send(input logic [DW-1:0] w, input logic pb,
                        input logic rdy_last);
        for (int k = 0; k < DW; k++) begin
            sin       = w[k];
            sin_start = (k == 0);
            if (rdy_last && !PAR && k == DW - 1)
                dout_ready = 1'b1;
            tick();
        end
        if (PAR) begin
            sin       = pb;
            sin_start = 1'b0;
            if (rdy_last)
                dout_ready = 1'b1;
            tick();
        end
        sin       = 1'b0;
        sin_start = 1'b0;
    endtask

    // Scoreboard side: a handshake seen mid-cycle completes at the next edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (overrun)
                ovr_seen++;
            if (dout_valid && dout_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", {16'h0, dout}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_dout", {16'h0, dout}, {16'h0, e.d});
                    chk("sb_perr", {31'h0, dout_perr}, {31'h0, e.p});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b0;
        sin        = 1'b0;
        sin_start  = 1'b0;
        dout_ready = 1'b0;
        tick();
        tick();
        chk("rst_dout", {16'h0, dout}, 32'h0);
        chk("rst_valid", {31'h0, dout_valid}, 32'h0);
        chk("rst_perr", {31'h0, dout_perr}, 32'h0);
        chk("rst_ovr", {31'h0, overrun}, 32'h0);
        resetn = 1'b1;
        tick();

        // Basic frame with a ready consumer.
        dout_ready = 1'b1;
        push(16'hA5C3, ^16'hA5C3);
        send(16'hA5C3, ^16'hA5C3, 1'b0);
        chk("basic_valid", {31'h0, dout_valid}, 32'h1);
        chk("basic_dout", {16'h0, dout}, 32'hA5C3);
        tick();
        chk("basic_valid_clr", {31'h0, dout_valid}, 32'h0);

        // Overrun: second word dropped while first is held.
        dout_ready = 1'b0;
        push(16'h1234, ^16'h1234);
        send(16'h1234, ^16'h1234, 1'b0);
        send(16'hBEEF, ^16'hBEEF, 1'b0);
        ovr_exp++;
        chk("ovr_pulse", {31'h0, overrun}, 32'h1);
        chk("ovr_dout_held", {16'h0, dout}, 32'h1234);
        chk("ovr_valid", {31'h0, dout_valid}, 32'h1);
        dout_ready = 1'b1;
        tick();
        chk("ovr_pulse_end", {31'h0, overrun}, 32'h0);
        chk("ovr_drained", {31'h0, dout_valid}, 32'h0);

        // Drain and load on the same edge.
        dout_ready = 1'b0;
        push(16'h1111, ^16'h1111);
        send(16'h1111, ^16'h1111, 1'b0);
        push(16'h2222, ^16'h2222);
        send(16'h2222, ^16'h2222, 1'b1);
        chk("swap_valid", {31'h0, dout_valid}, 32'h1);
        chk("swap_dout", {16'h0, dout}, 32'h2222);
        chk("swap_no_ovr", {31'h0, overrun}, 32'h0);
        tick();

        // Restart after 5 bits abandons the partial frame.
        for (int k = 0; k < 5; k++) begin
            sin       = 1'b1;
            sin_start = (k == 0);
            tick();
        end
        push(16'h0001, ^16'h0001);
        send(16'h0001, ^16'h0001, 1'b0);
        chk("restart_dout", {16'h0, dout}, 32'h0001);
        chk("restart_valid", {31'h0, dout_valid}, 32'h1);
        tick();

        // Reset mid-frame with a word pending.
        dout_ready = 1'b0;
        send(16'h5A5A, ^16'h5A5A, 1'b0);
        for (int k = 0; k < 6; k++) begin
            sin       = 1'b1;
            sin_start = (k == 0);
            tick();
        end
        sin_start = 1'b0;
        resetn    = 1'b0;
        tick();
        chk("mrst_dout", {16'h0, dout}, 32'h0);
        chk("mrst_valid", {31'h0, dout_valid}, 32'h0);
        chk("mrst_ovr", {31'h0, overrun}, 32'h0);
        resetn     = 1'b1;
        dout_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            sin = 1'b1;
            tick();
        end
        sin = 1'b0;
        chk("mrst_no_out", {31'h0, dout_valid}, 32'h0);

        // Parity cases (perr stays 0 without parity support).
        push(16'h0003, 1'b1);
        send(16'h0003, 1'b1, 1'b0);
        chk("par1_dout", {16'h0, dout}, 32'h0003);
        chk("par1_perr", {31'h0, dout_perr}, {31'h0, exp_perr(16'h0003, 1'b1)});
        tick();
        push(16'h0003, 1'b0);
        send(16'h0003, 1'b0, 1'b0);
        chk("par0_perr", {31'h0, dout_perr}, 32'h0);
        tick();
        tick();

        chk("sb_empty", q.size(), 32'h0);
        chk("ovr_count", ovr_seen, ovr_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
